// File: rtl/cpu_supervisor.sv
// cpu_supervisor: sits between a picorv32-class core memory port and the
// system bus. It sequences the core reset, gates bus requests, and detects
// bus errors, bus stalls and core traps. On a fault it records the cause and
// address, then either holds the core halted or restarts it after a delay.
module cpu_supervisor #(
  parameter int unsigned RESET_CYCLES   = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AUTO_RESTART   = 0,
  parameter int unsigned RESTART_DELAY  = 256,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   core_resetn,
  input  logic                   core_mem_valid,
  input  logic [ADDR_WIDTH-1:0]  core_mem_addr,
  output logic                   core_mem_ready,
  input  logic                   core_trap,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  input  logic                   bus_error,
  input  logic                   restart_req,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic [ADDR_WIDTH-1:0]  fault_addr,
  output logic [COUNT_WIDTH-1:0] fault_count
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BUS_ERR = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_TRAP    = 2'd3
  } cause_t;

  // Each counter is just wide enough to reach its own parameter value.
  localparam int unsigned HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned HALT_W  = $clog2(RESTART_DELAY + 1);
  // A disabled timeout still needs a legal one-bit counter.
  localparam int unsigned STALL_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HALT_W-1:0]  HALT_LAST  = HALT_W'(RESTART_DELAY - 1);
  localparam logic [STALL_W-1:0] STALL_LAST =
    STALL_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic [HALT_W-1:0]    halt_cnt_q;
  logic [STALL_W-1:0]   stall_cnt_q;

  logic                 stalled;
  logic                 err_hit;
  logic                 timeout_hit;
  logic                 trap_hit;
  logic                 fault_hit;
  cause_t               fault_code;
  logic                 enter_hold;

  // Fault detection in RUN, with bus error taking priority over timeout over trap.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    stalled     = 1'b0;
    err_hit     = 1'b0;
    timeout_hit = 1'b0;
    trap_hit    = 1'b0;
    fault_code  = CAUSE_NONE;
    if (state_q == ST_RUN) begin
      stalled     = core_mem_valid && !bus_ready;
      err_hit     = core_mem_valid && bus_error;
      timeout_hit = (TIMEOUT_CYCLES != 0) && stalled && (stall_cnt_q == STALL_LAST);
      trap_hit    = core_trap;
    end
    if (err_hit)          fault_code = CAUSE_BUS_ERR;
    else if (timeout_hit) fault_code = CAUSE_TIMEOUT;
    else if (trap_hit)    fault_code = CAUSE_TRAP;
    fault_hit = err_hit || timeout_hit || trap_hit;
  end

  // Next-state decode plus the combinational bus handshake outputs.
  always_comb begin
    state_d        = state_q;
    bus_valid      = 1'b0;
    core_mem_ready = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        // A restart request here is ignored; the hold count keeps running.
        if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        bus_valid      = core_mem_valid;
        core_mem_ready = bus_ready && !bus_error;
        if (restart_req)    state_d = ST_HOLD;
        else if (fault_hit) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (restart_req) begin
          state_d = ST_HOLD;
        end else if ((AUTO_RESTART != 0) && (halt_cnt_q == HALT_LAST)) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    enter_hold = (state_d == ST_HOLD) && (state_q != ST_HOLD);
  end

  // State register and the core reset, which is low only while holding.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q     <= ST_HOLD;
      core_resetn <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Core stays out of reset in HALT so its state is preserved for debug.
      core_resetn <= (state_d != ST_HOLD);
    end
  end

  // Reset hold counter: cleared on entry to HOLD, counts up while holding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt_q <= '0;
    end else if (enter_hold) begin
      hold_cnt_q <= '0;
    end else if ((state_q == ST_HOLD) && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

  // Halt dwell counter: cleared on entry to HALT, saturates at its last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      halt_cnt_q <= '0;
    end else if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
      halt_cnt_q <= '0;
    end else if ((state_q == ST_HALT) && (halt_cnt_q != HALT_LAST)) begin
      halt_cnt_q <= halt_cnt_q + 1'b1;
    end
  end

  // Stall counter: counts consecutive stalled cycles, clears on any other cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (!stalled || (TIMEOUT_CYCLES == 0)) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q != STALL_LAST) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Fault record: capture cause/address/count on a fault; HOLD entry clears the flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      fault_addr  <= '0;
      fault_count <= '0;
    end else begin
      if (fault_hit) begin
        fault_cause <= fault_code;
        fault_addr  <= core_mem_addr;
        if (fault_count != COUNT_MAX) fault_count <= fault_count + 1'b1;
      end
      if (enter_hold)     fault <= 1'b0;
      else if (fault_hit) fault <= 1'b1;
    end
  end

endmodule
